alarm_timer: RTL and testbench

Countdown timer and 1 Hz prescaler that serve the anti-theft controller's timer request interface. The controller drives `start_timer` and `timer_value`. This block counts the requested number of whole seconds and returns a one-cycle `timer_expired` pulse. It also generates the free-running `one_hz_enable` strobe used for LED blinking. It sits beside the anti-theft FSM in the alarm top level, clocked from the same `clk`.

---
 rtl/alarm_timer.sv | 81 ++++++++
 tb/tb_alarm_timer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
// alarm_timer: seconds countdown with free-running 1 Hz prescaler (optional abort via ALARM_TIMER_ABORT_EN)
module alarm_timer #(
    parameter int DIV   = 100_000_000,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_timer,
    input  logic [CNT_W-1:0] timer_value,
`ifdef ALARM_TIMER_ABORT_EN
    input  logic             timer_abort,
`endif
    output logic             timer_expired,
    output logic             one_hz_enable,
    output logic             busy,
    output logic [CNT_W-1:0] time_left
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] sec_cnt;
    logic          abort;

`ifdef ALARM_TIMER_ABORT_EN
    assign abort = timer_abort;
`else
    assign abort = 1'b0;
`endif

    assign busy = (state == COUNT);

    // free-running prescaler, strobe registered on the wrap edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt       <= '0;
            one_hz_enable <= 1'b0;
        end else begin
            pre_cnt       <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
            one_hz_enable <= (pre_cnt == LAST);
        end
    end

    // countdown fsm with its own phase counter so each second is exactly DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            time_left     <= '0;
            sec_cnt       <= '0;
            timer_expired <= 1'b0;
        end else begin
            timer_expired <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                time_left <= '0;
                sec_cnt   <= '0;
            end else if (start_timer) begin
                sec_cnt       <= '0;
                time_left     <= timer_value;
                state         <= (timer_value != '0) ? COUNT : IDLE;
                timer_expired <= (timer_value == '0);
            end else if (state == COUNT) begin
                if (sec_cnt == LAST) begin
                    sec_cnt <= '0;
                    if (time_left <= CNT_W'(1)) begin
                        time_left     <= '0;
                        state         <= IDLE;
                        timer_expired <= 1'b1;
                    end else begin
                        time_left <= time_left - 1'b1;
                    end
                end else begin
                    sec_cnt <= sec_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alarm_timer.sv
// tb_alarm_timer: directed self-checking bench for alarm_timer at DIV=4
module tb_alarm_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_timer = 1'b0;
    logic [3:0] timer_value = 4'd0;
`ifdef ALARM_TIMER_ABORT_EN
    logic       timer_abort = 1'b0;
`endif
    logic       timer_expired;
    logic       one_hz_enable;
    logic       busy;
    logic [3:0] time_left;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_timer #(.DIV(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start_timer(start_timer),
        .timer_value(timer_value),
`ifdef ALARM_TIMER_ABORT_EN
        .timer_abort(timer_abort),
`endif
        .timer_expired(timer_expired),
        .one_hz_enable(one_hz_enable),
        .busy(busy),
        .time_left(time_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        start_timer = 1'b1;
        timer_value = v;
        step();
        start_timer = 1'b0;
        timer_value = 4'd0;
    endtask

    task automatic phase_check(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            check("one_hz", one_hz_enable, (k % 4 == 0));
            check("idle_exp", timer_expired, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #1;
        check("rst_exp", timer_expired, 0);
        check("rst_hz", one_hz_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_left", time_left, 0);
        repeat (3) step();
        rst = 1'b0;
        phase_check(12);

        // basic countdown N=3
        load(4'd3);
        check("cd_left0", time_left, 3);
        check("cd_busy0", busy, 1);
        check("cd_exp0", timer_expired, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("cd_left", time_left, 3 - k / 4);
            check("cd_busy", busy, (k < 12));
            check("cd_exp", timer_expired, (k == 12));
        end
        step();
        check("cd_exp_drop", timer_expired, 0);

        // zero value
        load(4'd0);
        check("z_exp", timer_expired, 1);
        check("z_busy", busy, 0);
        check("z_left", time_left, 0);
        step();
        check("z_exp_drop", timer_expired, 0);
        check("z_busy2", busy, 0);

        // restart while busy
        load(4'd3);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("rs_exp_old", timer_expired, 0);
        end
        load(4'd2);
        check("rs_left", time_left, 2);
        check("rs_busy", busy, 1);
        for (int k = 7; k <= 14; k++) begin
            step();
            check("rs_exp", timer_expired, (k == 14));
            check("rs_left_k", time_left, (k < 10) ? 2 : (k < 14) ? 1 : 0);
        end
        step();

        // start on the expiry edge
        load(4'd1);
        for (int k = 1; k <= 3; k++) step();
        load(4'd5);
        check("ee_exp", timer_expired, 0);
        check("ee_left", time_left, 5);
        check("ee_busy", busy, 1);

        // start asserted during the pulse cycle
        load(4'd1);
        for (int k = 1; k <= 3; k++) step();
        step();
        check("hs_pulse", timer_expired, 1);
        load(4'd2);
        check("hs_drop", timer_expired, 0);
        check("hs_left", time_left, 2);
        check("hs_busy", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("hs_exp", timer_expired, (k == 8));
        end
        step();

        // cancel mid-count
        load(4'd2);
        for (int k = 1; k <= 4; k++) step();
        check("cx_left4", time_left, 1);
`ifdef ALARM_TIMER_ABORT_EN
        timer_abort = 1'b1;
        step();
        timer_abort = 1'b0;
        check("cx_busy", busy, 0);
        check("cx_left", time_left, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("cx_exp", timer_expired, 0);
            check("cx_busy_k", busy, 0);
        end
`else
        rst = 1'b1;
        #1;
        check("cx_busy", busy, 0);
        check("cx_left", time_left, 0);
        check("cx_exp", timer_expired, 0);
        check("cx_hz", one_hz_enable, 0);
        step();
        step();
        rst = 1'b0;
        phase_check(12);
        check("cx_left_end", time_left, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
